// File: rtl/out_port_pkg.sv
// rtl/out_port_pkg.sv - shared types and helpers for the multi-channel output port
//
// Purpose: mode encoding, mode field width and counter sizing helper used by
// out_port_chan and out_port_bank.
package out_port_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_LATCH = 2'd0,
    MODE_PULSE = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_RSVD  = 2'd3
  } out_mode_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One counter serves both pulse and blink timing, so it is sized for the
  // longer of the two; never narrower than one bit.
  function automatic int cnt_width(input int pulse_len, input int blink_div);
    int w;
    w = $clog2(max_int(pulse_len, blink_div));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/out_port_bank_if.sv
// rtl/out_port_bank_if.sv - write/readback bus bundle for out_port_bank
//
// Purpose: groups the CPU-side write strobe, channel address, data and the
// packed channel outputs. The readback pair exists only when
// OUT_PORT_BANK_READBACK_EN is defined.
// Signals:
//   wr_en, wr_ctrl, addr, D  bus -> port bank (write side)
//   Q, busy                  port bank -> indicators
//   rd_en / rd_data          optional readback
// Modports: master (bus side), slave (port bank side).
interface out_port_bank_if #(
  parameter int WIDTH  = 4,
  parameter int NUM_CH = 4,
  parameter int AW     = 2
);
  logic                      wr_en;
  logic                      wr_ctrl;
  logic [AW-1:0]             addr;
  logic [WIDTH-1:0]          D;
  logic [NUM_CH*WIDTH-1:0]   Q;
  logic [NUM_CH-1:0]         busy;
`ifdef OUT_PORT_BANK_READBACK_EN
  logic                      rd_en;
  logic [WIDTH-1:0]          rd_data;
`endif

  modport master (
    output wr_en, wr_ctrl, addr, D,
`ifdef OUT_PORT_BANK_READBACK_EN
    output rd_en,
    input  rd_data,
`endif
    input  Q, busy
  );

  modport slave (
    input  wr_en, wr_ctrl, addr, D,
`ifdef OUT_PORT_BANK_READBACK_EN
    input  rd_en,
    output rd_data,
`endif
    output Q, busy
  );

endinterface

// File: rtl/out_port_chan.sv
// rtl/out_port_chan.sv - one output channel: data/mode registers, pulse and blink timing
//
// Purpose: holds one WIDTH-bit output value and shows it in latch, timed-pulse
// or blink mode. Output and busy are registered.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   i_wr_data      data write to this channel (already address-decoded)
//   i_wr_mode      mode write to this channel (i_d[1:0] is the new mode)
//   i_d            write data
//   o_q, o_busy    channel output value and pulse-active flag
//   o_data, o_mode raw registers for readback (OUT_PORT_BANK_READBACK_EN only)
module out_port_chan
  import out_port_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PULSE_LEN = 8,
  parameter int BLINK_DIV = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_data,
  input  logic             i_wr_mode,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_busy
`ifdef OUT_PORT_BANK_READBACK_EN
  ,
  output logic [WIDTH-1:0] o_data,
  output out_mode_t        o_mode
`endif
);

  localparam int CW = cnt_width(PULSE_LEN, BLINK_DIV);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] BLINK_LOAD = CW'(BLINK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [WIDTH-1:0] r_data, w_data_nxt;
  out_mode_t        r_mode, w_mode_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_phase, w_phase_nxt;
  logic             r_busy, w_busy_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;

  always_comb begin
    w_data_nxt  = r_data;
    w_mode_nxt  = r_mode;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_busy_nxt  = r_busy;
    if (i_wr_mode) begin
      // Mode change restarts timing from a clean state; data is kept.
      w_mode_nxt  = out_mode_t'(i_d[MODE_W-1:0]);
      w_cnt_nxt   = '0;
      w_phase_nxt = 1'b0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_mode)
        MODE_PULSE: begin
          // A write takes priority over expiry, so a write on the last
          // visible cycle retriggers without busy dropping.
          if (i_wr_data) begin
            w_data_nxt = i_d;
            w_busy_nxt = 1'b1;
            w_cnt_nxt  = PULSE_LOAD;
          end else if (r_busy) begin
            if (r_cnt == '0) w_busy_nxt = 1'b0;
            else             w_cnt_nxt  = r_cnt - CNT_ONE;
          end
        end
        MODE_BLINK: begin
          if (i_wr_data) begin
            w_data_nxt  = i_d;
            w_phase_nxt = 1'b1;
            w_cnt_nxt   = BLINK_LOAD;
          end else if (r_cnt == '0) begin
            w_phase_nxt = ~r_phase;
            w_cnt_nxt   = BLINK_LOAD;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        default: begin
          // LATCH and the reserved encoding behave identically.
          if (i_wr_data) w_data_nxt = i_d;
        end
      endcase
    end

    case (w_mode_nxt)
      MODE_PULSE: w_q_nxt = w_busy_nxt  ? w_data_nxt : '0;
      MODE_BLINK: w_q_nxt = w_phase_nxt ? w_data_nxt : '0;
      default:    w_q_nxt = w_data_nxt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_mode  <= MODE_LATCH;
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_busy  <= 1'b0;
      r_q     <= '0;
    end else begin
      r_data  <= w_data_nxt;
      r_mode  <= w_mode_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
      r_busy  <= w_busy_nxt;
      r_q     <= w_q_nxt;
    end
  end

  assign o_q    = r_q;
  assign o_busy = r_busy;
`ifdef OUT_PORT_BANK_READBACK_EN
  assign o_data = r_data;
  assign o_mode = r_mode;
`endif

endmodule

// File: rtl/out_port_bank.sv
// rtl/out_port_bank.sv - memory-mapped bank of NUM_CH latch/pulse/blink output channels
//
// Purpose: decodes bus writes to one of NUM_CH channels and packs the channel
// outputs; channel i drives Q[i*WIDTH +: WIDTH] and busy[i].
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    out_port_bank_if.slave (wr_en, wr_ctrl, addr, D in; Q, busy out)
// Optional: OUT_PORT_BANK_READBACK_EN adds bus.rd_en / bus.rd_data, a
// registered readback of the addressed channel's data (or mode with wr_ctrl).
module out_port_bank
  import out_port_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int NUM_CH    = 4,
  parameter int PULSE_LEN = 8,
  parameter int BLINK_DIV = 16,
  localparam int AW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  out_port_bank_if.slave bus
);

  localparam logic [AW:0] NUM_CH_W = (AW+1)'(NUM_CH);

  logic                    w_addr_ok;
  logic                    w_wr_ok;
  logic [NUM_CH*WIDTH-1:0] w_q;
  logic [NUM_CH-1:0]       w_busy;

  // Addresses past the last channel are silently dropped.
  assign w_addr_ok = ({1'b0, bus.addr} < NUM_CH_W);
  assign w_wr_ok   = bus.wr_en & w_addr_ok;

`ifdef OUT_PORT_BANK_READBACK_EN
  logic [WIDTH-1:0] w_data [NUM_CH];
  out_mode_t        w_mode [NUM_CH];
  logic [WIDTH-1:0] r_rd_data;
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic w_sel;
    assign w_sel = w_wr_ok && (bus.addr == AW'(gi));

    out_port_chan #(
      .WIDTH     (WIDTH),
      .PULSE_LEN (PULSE_LEN),
      .BLINK_DIV (BLINK_DIV)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .i_wr_data (w_sel & ~bus.wr_ctrl),
      .i_wr_mode (w_sel &  bus.wr_ctrl),
      .i_d       (bus.D),
      .o_q       (w_q[gi*WIDTH +: WIDTH]),
      .o_busy    (w_busy[gi])
`ifdef OUT_PORT_BANK_READBACK_EN
      ,
      .o_data    (w_data[gi]),
      .o_mode    (w_mode[gi])
`endif
    );
  end

  assign bus.Q    = w_q;
  assign bus.busy = w_busy;

`ifdef OUT_PORT_BANK_READBACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (bus.rd_en && w_addr_ok) begin
      r_rd_data <= bus.wr_ctrl ? WIDTH'(w_mode[bus.addr]) : w_data[bus.addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign bus.rd_data = r_rd_data;
`endif

endmodule

// File: tb/tb_out_port_bank.sv
// tb/tb_out_port_bank.sv - scoreboard bench for out_port_bank
module tb_out_port_bank;

  localparam int WIDTH     = 4;
  localparam int NUM_CH    = 4;
  localparam int PULSE_LEN = 8;
  localparam int BLINK_DIV = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  out_port_bank_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .AW(2)) bus ();
  out_port_bank #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .PULSE_LEN(PULSE_LEN), .BLINK_DIV(BLINK_DIV))
    dut (.clk(clk), .reset(reset), .bus(bus));

  // Three-channel instance: address 3 is out of range here.
  out_port_bank_if #(.WIDTH(WIDTH), .NUM_CH(3), .AW(2)) bus3 ();
  out_port_bank #(.WIDTH(WIDTH), .NUM_CH(3), .PULSE_LEN(PULSE_LEN), .BLINK_DIV(BLINK_DIV))
    dut3 (.clk(clk), .reset(reset), .bus(bus3));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: each channel's output is derived from its mode and the number
  // of cycles elapsed since its last accepted write.
  logic [3:0] m_data  [NUM_CH];
  logic [1:0] m_mode  [NUM_CH];
  bit         m_armed [NUM_CH];
  int         m_age   [NUM_CH];

  typedef struct {
    logic [15:0] q;
    logic [3:0]  busy;
  } exp_t;
  exp_t sb[$];

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_data[c] = '0; m_mode[c] = 2'd0; m_armed[c] = 1'b0; m_age[c] = 0;
    end
  endtask

  task automatic model_edge(input logic we, input logic ctrl, input logic [1:0] a, input logic [3:0] d);
    for (int c = 0; c < NUM_CH; c++) begin
      if (we && (int'(a) == c)) begin
        if (ctrl) begin
          m_mode[c] = d[1:0]; m_armed[c] = 1'b0;
        end else begin
          m_data[c] = d; m_armed[c] = (m_mode[c] == 2'd1) || (m_mode[c] == 2'd2);
        end
        m_age[c] = 0;
      end else if (m_age[c] < 1000000) begin
        m_age[c]++;
      end
    end
  endtask

  function automatic logic exp_busy(input int c);
    return (m_mode[c] == 2'd1) && m_armed[c] && (m_age[c] < PULSE_LEN);
  endfunction

  function automatic logic [3:0] exp_q(input int c);
    case (m_mode[c])
      2'd1: return exp_busy(c) ? m_data[c] : 4'h0;
      2'd2: begin
        if (m_armed[c]) return (((m_age[c] / BLINK_DIV) % 2) == 0) ? m_data[c] : 4'h0;
        // After a bare mode change the off phase lasts one cycle, then on.
        return ((m_age[c] >= 1) && ((((m_age[c] - 1) / BLINK_DIV) % 2) == 0)) ? m_data[c] : 4'h0;
      end
      default: return m_data[c];
    endcase
  endfunction

  task automatic push_exp();
    exp_t e;
    for (int c = 0; c < NUM_CH; c++) begin
      e.q[c*4 +: 4] = exp_q(c);
      e.busy[c]     = exp_busy(c);
    end
    sb.push_back(e);
  endtask

  task automatic cycle(input logic we, input logic ctrl, input logic [1:0] a, input logic [3:0] d,
                       input string tag);
    exp_t e;
    bus.wr_en = we; bus.wr_ctrl = ctrl; bus.addr = a; bus.D = d;
    model_edge(we, ctrl, a, d);
    push_exp();
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, "_q"}, 32'(bus.Q), 32'(e.q));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(e.busy));
    bus.wr_en = 1'b0; bus.wr_ctrl = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 2'd0, 4'h0, tag);
  endtask

`ifdef OUT_PORT_BANK_READBACK_EN
  task automatic rd_cycle(input logic ctrl, input logic [1:0] a, input string tag);
    logic [3:0] exp_rd;
    exp_rd = ctrl ? {2'b00, m_mode[a]} : m_data[a];
    bus.rd_en = 1'b1;
    bus.addr = a; bus.wr_ctrl = ctrl; bus.wr_en = 1'b0;
    model_edge(1'b0, 1'b0, 2'd0, 4'h0);
    push_exp();
    @(posedge clk);
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk(tag, 32'(bus.rd_data), 32'(exp_rd));
    void'(sb.pop_front());
    bus.wr_ctrl = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.wr_en = 0; bus.wr_ctrl = 0; bus.addr = '0; bus.D = '0;
    bus3.wr_en = 0; bus3.wr_ctrl = 0; bus3.addr = '0; bus3.D = '0;
`ifdef OUT_PORT_BANK_READBACK_EN
    bus.rd_en = 0; bus3.rd_en = 0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_q", 32'(bus.Q), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst3_q", 32'(bus3.Q), 32'h0);
    reset = 1'b0;

    // Latch
    cycle(1'b1, 1'b0, 2'd1, 4'h5, "latch");
    idle(2, "latch_hold");

    // Out-of-range address on the three-channel bank
    bus3.wr_en = 1; bus3.wr_ctrl = 0; bus3.addr = 2'd0; bus3.D = 4'hC;
    idle(1, "inv_a");
    bus3.addr = 2'd3; bus3.D = 4'hE;
    idle(1, "inv_b");
    bus3.wr_ctrl = 1; bus3.D = 4'h1;
    idle(1, "inv_c");
    bus3.wr_en = 0; bus3.wr_ctrl = 0;
    idle(1, "inv_d");
    chk("inv3_q", 32'(bus3.Q), 32'h00C);
    chk("inv3_busy", 32'(bus3.busy), 32'h0);

    // Pulse, retrigger at cycle 4, zero-valued pulse
    cycle(1'b1, 1'b1, 2'd0, 4'h1, "pmode");
    cycle(1'b1, 1'b0, 2'd0, 4'h9, "pulse");
    idle(3, "pulse_run");
    cycle(1'b1, 1'b0, 2'd0, 4'h3, "retrig");
    idle(10, "pulse_tail");
    cycle(1'b1, 1'b0, 2'd0, 4'h0, "pzero");
    idle(9, "pzero_run");

    // Write on the same cycle the pulse counter expires
    cycle(1'b1, 1'b0, 2'd0, 4'h4, "coll");
    idle(7, "coll_run");
    cycle(1'b1, 1'b0, 2'd0, 4'h6, "coll_wr");
    chk("coll_busy_held", 32'(bus.busy[0]), 32'h1);
    idle(9, "coll_tail");

    // Blink on ch3, then back to latch
    cycle(1'b1, 1'b1, 2'd3, 4'h2, "bmode");
    cycle(1'b1, 1'b0, 2'd3, 4'hF, "blink");
    idle(100, "blink_run");
    cycle(1'b1, 1'b1, 2'd3, 4'h0, "b2latch");
    idle(3, "latch_f");

    // Asynchronous reset in the middle of a blink on ch2
    cycle(1'b1, 1'b1, 2'd2, 4'h2, "b2mode");
    cycle(1'b1, 1'b0, 2'd2, 4'hA, "b2data");
    idle(3, "b2run");
    reset = 1'b1;
    #1;
    chk("rst_mid_q", 32'(bus.Q), 32'h0);
    chk("rst_mid_busy", 32'(bus.busy), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 1'b0, 2'd2, 4'h7, "post_rst");
    idle(20, "post_rst_latch");

`ifdef OUT_PORT_BANK_READBACK_EN
    cycle(1'b1, 1'b0, 2'd1, 4'h6, "rb_wr");
    rd_cycle(1'b0, 2'd1, "rb_data");
    cycle(1'b1, 1'b1, 2'd1, 4'h3, "rb_mode_wr");
    rd_cycle(1'b1, 2'd1, "rb_mode");
    rd_cycle(1'b1, 2'd3, "rb_mode3");
    bus3.rd_en = 1; bus3.addr = 2'd3; bus3.wr_ctrl = 0;
    @(posedge clk);
    @(negedge clk);
    bus3.rd_en = 0;
    chk("rb_invalid", 32'(bus3.rd_data), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
